// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM mic clock generator, 1-bit sampler and sinc2 CIC decimator to unsigned PCM.
// Ports: clk/rst_n (async active-low) system clock and reset; enable runs the front end;
// micData is the PDM bit stream; mic_clk/micLRSel drive the microphone; sample_valid pulses
// for one clk when sample_data (held) updates; running is high once samples are flowing.
module pdm_decimator #(
    parameter int CLK_HALF = 50,
    parameter int DECIM    = 32,
    parameter int SETTLE   = 2,
    parameter int OUT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             micData,
    output logic             mic_clk,
    output logic             micLRSel,
    output logic             sample_valid,
    output logic [OUT_W-1:0] sample_data,
    output logic             running
);
    localparam int LD    = $clog2(DECIM);
    localparam int ACC_W = 2 * LD + 1;
    localparam int DW    = $clog2(CLK_HALF);
    localparam int SW    = $clog2(SETTLE + 1) + 1;
    localparam int SH    = ACC_W - 1 - OUT_W;
    localparam int SHR   = SH > 0 ? SH : 0;
    localparam int SHL   = SH < 0 ? -SH : 0;
    localparam logic [ACC_W-1:0] SAT = {1'b0, {(ACC_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, SETL, RUN} state_t;

    state_t             state;
    logic [DW-1:0]      div_cnt;
    logic [LD-1:0]      bit_cnt;
    logic [SW-1:0]      set_cnt;
    logic [ACC_W-1:0]   i1, i2, d1, d2;
    logic               pdm_tick, dec_tick;
    logic [ACC_W-1:0]   i1_n, i2_n, c1, c2, res;
    logic [OUT_W+ACC_W-1:0] wide;
    logic [OUT_W-1:0]   out_v;

    assign micLRSel = 1'b0;

    // The PDM tick is the falling edge of mic_clk, i.e. the end of the high (left) phase.
    assign pdm_tick = enable && mic_clk && div_cnt == DW'(CLK_HALF - 1);
    assign dec_tick = pdm_tick && bit_cnt == LD'(DECIM - 1);

    // Combs see the integrators including the bit sampled this tick; modulo wrap is intended.
    assign i1_n  = i1 + ACC_W'(micData);
    assign i2_n  = i2 + i1_n;
    assign c1    = i2_n - d1;
    assign c2    = c1 - d2;
    assign res   = c2 > SAT ? SAT : c2;
    assign wide  = {{OUT_W{1'b0}}, res};
    assign out_v = OUT_W'((wide >> SHR) << SHL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            mic_clk      <= 1'b0;
            bit_cnt      <= '0;
            set_cnt      <= '0;
            i1           <= '0;
            i2           <= '0;
            d1           <= '0;
            d2           <= '0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            running      <= 1'b0;
        end else if (!enable) begin
            state        <= IDLE;
            div_cnt      <= '0;
            mic_clk      <= 1'b0;
            bit_cnt      <= '0;
            set_cnt      <= '0;
            i1           <= '0;
            i2           <= '0;
            d1           <= '0;
            d2           <= '0;
            sample_valid <= 1'b0;
            running      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            div_cnt      <= div_cnt == DW'(CLK_HALF - 1) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DW'(CLK_HALF - 1))
                mic_clk <= ~mic_clk;
            if (state == IDLE)
                state <= SETTLE == 0 ? RUN : SETL;
            if (pdm_tick) begin
                i1      <= i1_n;
                i2      <= i2_n;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (dec_tick) begin
                d1 <= i2_n;
                d2 <= c1;
                if (state == RUN) begin
                    sample_valid <= 1'b1;
                    sample_data  <= out_v;
                    running      <= 1'b1;
                end else if (state == SETL) begin
                    set_cnt <= set_cnt + 1'b1;
                    if (set_cnt == SW'(SETTLE - 1))
                        state <= RUN;
                end
            end
        end
    end
endmodule
